// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the tone sequencer slice.
//   state_t        : FSM state encoding (IDLE, LOAD, PLAY, MANUAL)
//   NUM_NOTES_MAX  : size of the tone table
//   DWELL_W        : width of the dwell counter / dwell input
//   TONE_TABLE     : half-period counts at 50 MHz for C5..C6
//   tone_lookup()  : table read by a 3-bit index
// ---------------------------------------------------------------------------
package tone_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_PLAY   = 2'd2,
      ST_MANUAL = 2'd3
   } state_t;

   localparam int NUM_NOTES_MAX = 8;
   localparam int DWELL_W       = 32;

   localparam logic [31:0] TONE_TABLE [0:NUM_NOTES_MAX-1] = '{
      32'd47778, 32'd42590, 32'd37936, 32'd35816,
      32'd31888, 32'd28409, 32'd25303, 32'd23889
   };

   function automatic logic [31:0] tone_lookup(input logic [2:0] sel);
      return TONE_TABLE[sel];
   endfunction

endpackage

// File: rtl/tone_dwell_timer.sv
// ---------------------------------------------------------------------------
// tone_dwell_timer
// Down-counter that measures how many PLAY cycles a note has left.
//   clock_in : system clock
//   reset    : asynchronous active-high reset, clears the count to 0
//   load     : reload the count from value (asserted while the FSM is in LOAD)
//   value    : reload value, already clamped to at least 1 by the caller
//   expired  : high while the count sits at 1, i.e. the current cycle is the
//              last PLAY cycle of the note
// ---------------------------------------------------------------------------
module tone_dwell_timer
   import tone_pkg::*;
(
   input  logic               clock_in,
   input  logic               reset,
   input  logic               load,
   input  logic [DWELL_W-1:0] value,
   output logic               expired
);

   logic [DWELL_W-1:0] count;

   // The counter stops at 1 instead of wrapping, so a note whose dwell has
   // expired keeps reporting expiry until the next reload.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count > DWELL_W'(1)) begin
         count <= count - DWELL_W'(1);
      end
   end

   assign expired = (count == DWELL_W'(1));

endmodule

// File: rtl/tone_sequencer.sv
// ---------------------------------------------------------------------------
// tone_sequencer
// Plays the first NUM_NOTES entries of the tone table in order, each for a
// programmable number of cycles, or holds a single manually selected note.
// The downstream clock divider lives outside this block; it is fed through
// count_end and div_reset.
//   clock_in  : system clock
//   reset     : asynchronous active-high reset
//   start     : starts a sequence when seen in IDLE with mode = 0
//   stop      : aborts a running sequence (LOAD or PLAY)
//   mode      : 0 = sequence mode, 1 = manual mode
//   note_sel  : table index used in manual mode
//   dwell     : PLAY cycles per note, sampled in LOAD (0 behaves as 1)
//   count_end : divisor value for the clock divider
//   div_reset : holds the clock divider in reset while high
//   tone_en   : divider output is a valid tone
//   note_idx  : table index currently driven on count_end
//   busy      : high in LOAD and PLAY
//   done      : one-cycle pulse after the last note completes normally
// ---------------------------------------------------------------------------
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int NUM_NOTES = 8
)(
   input  logic               clock_in,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [2:0]         note_sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [31:0]        count_end,
   output logic               div_reset,
   output logic               tone_en,
   output logic [2:0]         note_idx,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_NOTES - 1);

   state_t             state;
   logic [2:0]         idx;
   logic [DWELL_W-1:0] dwell_load;
   logic               dwell_expired;

   // A dwell of 0 would otherwise leave the note with no PLAY cycle at all.
   assign dwell_load = (dwell == '0) ? DWELL_W'(1) : dwell;

   tone_dwell_timer u_dwell (
      .clock_in (clock_in),
      .reset    (reset),
      .load     (state == ST_LOAD),
      .value    (dwell_load),
      .expired  (dwell_expired)
   );

   // Single Moore FSM. Every output is written alongside the state it
   // belongs to, so all outputs come straight from flops. div_reset is
   // raised on every cycle where the divider sees a new count_end (LOAD, the
   // first MANUAL cycle, the cycle after a manual note change) so the
   // divider restarts cleanly; tone_en is its complement outside IDLE.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         idx       <= '0;
         count_end <= '0;
         note_idx  <= '0;
         div_reset <= 1'b1;
         tone_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mode) begin
                  state     <= ST_MANUAL;
                  count_end <= tone_lookup(note_sel);
                  note_idx  <= note_sel;
                  div_reset <= 1'b1;
                  tone_en   <= 1'b0;
                  busy      <= 1'b0;
               end else if (start) begin
                  state     <= ST_LOAD;
                  idx       <= '0;
                  count_end <= tone_lookup(3'd0);
                  note_idx  <= '0;
                  div_reset <= 1'b1;
                  tone_en   <= 1'b0;
                  busy      <= 1'b1;
               end
            end

            ST_LOAD: begin
               if (stop) begin
                  state     <= ST_IDLE;
                  div_reset <= 1'b1;
                  tone_en   <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  state     <= ST_PLAY;
                  div_reset <= 1'b0;
                  tone_en   <= 1'b1;
                  busy      <= 1'b1;
               end
            end

            // stop is checked before expiry so an abort on the final cycle
            // of the last note never produces a done pulse.
            ST_PLAY: begin
               if (stop) begin
                  state     <= ST_IDLE;
                  div_reset <= 1'b1;
                  tone_en   <= 1'b0;
                  busy      <= 1'b0;
               end else if (dwell_expired) begin
                  if (idx != LAST_IDX) begin
                     state     <= ST_LOAD;
                     idx       <= idx + 3'd1;
                     count_end <= tone_lookup(idx + 3'd1);
                     note_idx  <= idx + 3'd1;
                     div_reset <= 1'b1;
                     tone_en   <= 1'b0;
                     busy      <= 1'b1;
                  end else begin
                     state     <= ST_IDLE;
                     div_reset <= 1'b1;
                     tone_en   <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end

            ST_MANUAL: begin
               if (!mode) begin
                  state     <= ST_IDLE;
                  div_reset <= 1'b1;
                  tone_en   <= 1'b0;
               end else if (note_sel != note_idx) begin
                  count_end <= tone_lookup(note_sel);
                  note_idx  <= note_sel;
                  div_reset <= 1'b1;
                  tone_en   <= 1'b0;
               end else begin
                  div_reset <= 1'b0;
                  tone_en   <= 1'b1;
               end
            end

            default: begin
               state     <= ST_IDLE;
               div_reset <= 1'b1;
               tone_en   <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
